// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares one single-port synchronous data memory between the CPU controller
// (load/store) and a host/debug loader port. One access is arbitrated per
// cycle. The CPU has fixed priority. A wait counter stops the CPU from
// starving the host: after HOST_STARVE_MAX lost cycles the host wins a tie.
//
// Timing: requests sampled in cycle t go out on the registered Mem* bus in
// cycle t+1, together with the winner's Gnt pulse. For reads, the memory
// returns data in t+2, and that data is forwarded with an RValid pulse.
//
// Ports
//   Clk, Rst                 clock (rising edge), async active-high reset
//   CpuReq/Write/Addr/WData  CPU request, held until CpuGnt
//   CpuGnt                   CPU access is on the memory bus this cycle
//   CpuRValid/CpuRData       CPU read return (data is 0 when not valid)
//   HostReq/Write/Addr/WData host request, held until HostGnt
//   HostGnt                  host access is on the memory bus this cycle
//   HostRValid/HostRData     host read return (data is 0 when not valid)
//   MemAddr/MemWData/MemWrite registered memory command
//   MemRData                 memory read data, valid the cycle after MemAddr
//   Owner                    bus owner this cycle: 00 idle, 01 CPU, 10 host
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int ADDR_W          = 8,
    parameter int DATA_W          = 16,
    parameter int HOST_STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Rst,

    input  logic              CpuReq,
    input  logic              CpuWrite,
    input  logic [ADDR_W-1:0] CpuAddr,
    input  logic [DATA_W-1:0] CpuWData,
    output logic              CpuGnt,
    output logic              CpuRValid,
    output logic [DATA_W-1:0] CpuRData,

    input  logic              HostReq,
    input  logic              HostWrite,
    input  logic [ADDR_W-1:0] HostAddr,
    input  logic [DATA_W-1:0] HostWData,
    output logic              HostGnt,
    output logic              HostRValid,
    output logic [DATA_W-1:0] HostRData,

    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] MemRData,

    output logic [1:0]        Owner
);

    localparam int CNT_W = $clog2(HOST_STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOST_STARVE_MAX);

    // The state encoding is the Owner code, so Owner is a direct view of the state.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_HOST = 2'b10
    } state_e;

    state_e            state_q,        state_d;
    logic [CNT_W-1:0]  wait_cnt_q,     wait_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q,     mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,    mem_wdata_d;
    logic              mem_write_q,    mem_write_d;
    logic              cpu_rd_pend_q,  cpu_rd_pend_d;
    logic              host_rd_pend_q, host_rd_pend_d;
    logic              host_wins;

    // Arbitration, command capture and read-return pipeline.
    always_comb begin
        // NOTE: every signal this block writes gets a default first, so no latch is inferred.
        state_d     = IDLE;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_write_d = 1'b0;
        wait_cnt_d  = wait_cnt_q;

        // The host wins if it is alone, or if it has already lost HOST_STARVE_MAX cycles.
        host_wins = HostReq && (!CpuReq || (wait_cnt_q == CNT_MAX));

        if (host_wins) begin
            state_d     = OWN_HOST;
            mem_addr_d  = HostAddr;
            mem_wdata_d = HostWData;
            mem_write_d = HostWrite;
        end else if (CpuReq) begin
            state_d     = OWN_CPU;
            mem_addr_d  = CpuAddr;
            mem_wdata_d = CpuWData;
            mem_write_d = CpuWrite;
        end

        // Count the cycles the host waits behind the CPU. Saturate at the limit.
        if (!HostReq || host_wins) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end

        // A read on the bus this cycle returns its data next cycle.
        // Each port has its own flag, so adjacent reads from both ports come back in order.
        cpu_rd_pend_d  = (state_q == OWN_CPU)  && !mem_write_q;
        host_rd_pend_d = (state_q == OWN_HOST) && !mem_write_q;
    end

    // NOTE: registers use non-blocking assignments, so every flop updates from pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q        <= IDLE;
            wait_cnt_q     <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_write_q    <= 1'b0;
            cpu_rd_pend_q  <= 1'b0;
            host_rd_pend_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_write_q    <= mem_write_d;
            cpu_rd_pend_q  <= cpu_rd_pend_d;
            host_rd_pend_q <= host_rd_pend_d;
        end
    end

    assign Owner      = state_q;
    assign CpuGnt     = (state_q == OWN_CPU);
    assign HostGnt    = (state_q == OWN_HOST);
    assign MemAddr    = mem_addr_q;
    assign MemWData   = mem_wdata_q;
    assign MemWrite   = mem_write_q;

    // Read data is gated by the pending flag. The port sees zero outside its valid pulse,
    // and reset clears the flag, so read data is also zero during reset.
    assign CpuRValid  = cpu_rd_pend_q;
    assign CpuRData   = cpu_rd_pend_q  ? MemRData : '0;
    assign HostRValid = host_rd_pend_q;
    assign HostRData  = host_rd_pend_q ? MemRData : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Self-checking bench for data_mem_arbiter. The bench contains a synchronous
// 256x16 memory that serves MemAddr/MemWData/MemWrite. Directed scenarios are
// followed by a randomized run. That run is compared against a transaction-level
// reference built from the arbitration rules and a shadow memory.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int MAX    = 4;

    logic              Clk = 1'b0;
    logic              Rst;
    logic              CpuReq, CpuWrite;
    logic [ADDR_W-1:0] CpuAddr;
    logic [DATA_W-1:0] CpuWData;
    logic              CpuGnt, CpuRValid;
    logic [DATA_W-1:0] CpuRData;
    logic              HostReq, HostWrite;
    logic [ADDR_W-1:0] HostAddr;
    logic [DATA_W-1:0] HostWData;
    logic              HostGnt, HostRValid;
    logic [DATA_W-1:0] HostRData;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic              MemWrite;
    logic [DATA_W-1:0] MemRData;
    logic [1:0]        Owner;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] mem     [256];
    logic [DATA_W-1:0] ref_mem [256];

    data_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOST_STARVE_MAX(MAX)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .CpuReq(CpuReq), .CpuWrite(CpuWrite), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
        .CpuGnt(CpuGnt), .CpuRValid(CpuRValid), .CpuRData(CpuRData),
        .HostReq(HostReq), .HostWrite(HostWrite), .HostAddr(HostAddr), .HostWData(HostWData),
        .HostGnt(HostGnt), .HostRValid(HostRValid), .HostRData(HostRData),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemWrite(MemWrite), .MemRData(MemRData),
        .Owner(Owner)
    );

    always #5 Clk = ~Clk;

    // Memory contents before any write.
    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return {8'hA5, a};
    endfunction

    // Single-port synchronous memory. It is read-first and returns data one cycle after the address.
    initial begin : memory_model
        for (int i = 0; i < 256; i++) mem[i] = init_val(8'(i));
        MemRData = '0;
        forever begin
            @(posedge Clk);
            if (MemWrite) mem[MemAddr] <= MemWData;
            MemRData <= mem[MemAddr];
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t expected end before 500000", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_cpu(input logic req, input logic wr, input logic [7:0] a, input logic [15:0] d);
        CpuReq = req; CpuWrite = wr; CpuAddr = a; CpuWData = d;
    endtask

    task automatic drive_host(input logic req, input logic wr, input logic [7:0] a, input logic [15:0] d);
        HostReq = req; HostWrite = wr; HostAddr = a; HostWData = d;
    endtask

    task automatic test_reset();
        logic [73:0] all_out;
        Rst = 1'b1;
        drive_cpu(0, 0, 0, 0);
        drive_host(0, 0, 0, 0);
        #3;
        all_out = {CpuGnt, HostGnt, CpuRValid, HostRValid, CpuRData, HostRData,
                   MemAddr, MemWData, MemWrite, Owner};
        n_checks++; if (all_out !== '0) begin n_errors++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
        tick(); tick();
        Rst = 1'b0;
        // Start a CPU read, then hit reset while the read is on the bus.
        drive_cpu(1, 0, 8'h20, 16'h0);
        tick();
        n_checks++; if (CpuGnt !== 1'b1) begin n_errors++; $display("FAIL reset_pre_gnt: CpuGnt=%b expected 1", CpuGnt); end
        n_checks++; if (MemAddr !== 8'h20) begin n_errors++; $display("FAIL reset_pre_addr: MemAddr=%h expected 20", MemAddr); end
        drive_cpu(0, 0, 0, 0);
        #3;
        Rst = 1'b1;
        #1;
        all_out = {CpuGnt, HostGnt, CpuRValid, HostRValid, CpuRData, HostRData,
                   MemAddr, MemWData, MemWrite, Owner};
        n_checks++; if (all_out !== '0) begin n_errors++; $display("FAIL reset_mid_read: outputs=%h expected 0", all_out); end
        tick();
        #2;
        Rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if ({CpuRValid, HostRValid, CpuGnt, HostGnt} !== 4'b0)
                begin n_errors++; $display("FAIL reset_after_release: cyc=%0d rvalid/gnt=%b expected 0000", k, {CpuRValid, HostRValid, CpuGnt, HostGnt}); end
        end
    endtask

    task automatic test_cpu_write_read();
        drive_cpu(1, 1, 8'h10, 16'h005A);
        tick();
        n_checks++; if (CpuGnt !== 1'b1 || HostGnt !== 1'b0) begin n_errors++; $display("FAIL wr_gnt: CpuGnt=%b HostGnt=%b expected 1 0", CpuGnt, HostGnt); end
        n_checks++; if (Owner !== 2'b01) begin n_errors++; $display("FAIL wr_owner: Owner=%b expected 01", Owner); end
        n_checks++; if ({MemWrite, MemAddr, MemWData} !== {1'b1, 8'h10, 16'h005A})
            begin n_errors++; $display("FAIL wr_cmd: we=%b addr=%h wdata=%h expected 1 10 005a", MemWrite, MemAddr, MemWData); end
        drive_cpu(1, 0, 8'h10, 16'h0);
        tick();
        n_checks++; if (CpuGnt !== 1'b1 || MemWrite !== 1'b0 || MemAddr !== 8'h10)
            begin n_errors++; $display("FAIL rd_cmd: gnt=%b we=%b addr=%h expected 1 0 10", CpuGnt, MemWrite, MemAddr); end
        n_checks++; if (CpuRValid !== 1'b0) begin n_errors++; $display("FAIL wr_no_rvalid: CpuRValid=%b expected 0", CpuRValid); end
        drive_cpu(0, 0, 0, 0);
        tick();
        n_checks++; if (CpuRValid !== 1'b1 || CpuRData !== 16'h005A)
            begin n_errors++; $display("FAIL rd_data: rvalid=%b data=%h expected 1 005a", CpuRValid, CpuRData); end
        n_checks++; if (CpuGnt !== 1'b0 || Owner !== 2'b00) begin n_errors++; $display("FAIL rd_idle: gnt=%b owner=%b expected 0 00", CpuGnt, Owner); end
        tick();
        n_checks++; if (CpuRValid !== 1'b0 || CpuRData !== 16'h0)
            begin n_errors++; $display("FAIL rd_pulse: rvalid=%b data=%h expected 0 0000", CpuRValid, CpuRData); end
    endtask

    task automatic test_simultaneous();
        drive_cpu(1, 0, 8'h30, 16'h0);
        drive_host(1, 0, 8'h31, 16'h0);
        tick();
        n_checks++; if ({CpuGnt, HostGnt, Owner} !== 4'b1001)
            begin n_errors++; $display("FAIL sim_first: cpu=%b host=%b owner=%b expected 1 0 01", CpuGnt, HostGnt, Owner); end
        n_checks++; if (MemAddr !== 8'h30) begin n_errors++; $display("FAIL sim_first_addr: MemAddr=%h expected 30", MemAddr); end
        drive_cpu(0, 0, 0, 0);
        tick();
        n_checks++; if ({CpuGnt, HostGnt, Owner} !== 4'b0110)
            begin n_errors++; $display("FAIL sim_second: cpu=%b host=%b owner=%b expected 0 1 10", CpuGnt, HostGnt, Owner); end
        n_checks++; if (MemAddr !== 8'h31) begin n_errors++; $display("FAIL sim_second_addr: MemAddr=%h expected 31", MemAddr); end
        n_checks++; if (CpuRValid !== 1'b1 || CpuRData !== init_val(8'h30) || HostRValid !== 1'b0 || HostRData !== 16'h0)
            begin n_errors++; $display("FAIL sim_cpu_ret: crv=%b crd=%h hrv=%b hrd=%h expected 1 %h 0 0000", CpuRValid, CpuRData, HostRValid, HostRData, init_val(8'h30)); end
        drive_host(0, 0, 0, 0);
        tick();
        n_checks++; if (HostRValid !== 1'b1 || HostRData !== init_val(8'h31) || CpuRValid !== 1'b0)
            begin n_errors++; $display("FAIL sim_host_ret: hrv=%b hrd=%h crv=%b expected 1 %h 0", HostRValid, HostRData, CpuRValid, init_val(8'h31)); end
        tick();
    endtask

    task automatic test_starvation();
        logic exp_h, prev_h;
        drive_cpu(1, 0, 8'h40, 16'h0);
        drive_host(1, 0, 8'h41, 16'h0);
        for (int k = 1; k <= 11; k++) begin
            tick();
            // Every (MAX+1)th grant goes to the host while both ports request.
            exp_h = (k <= 10) && ((k % (MAX + 1)) == 0);
            n_checks++; if (HostGnt !== exp_h || CpuGnt !== ((k <= 10) && !exp_h))
                begin n_errors++; $display("FAIL starve_gnt: k=%0d cpu=%b host=%b expected %b %b", k, CpuGnt, HostGnt, (k <= 10) && !exp_h, exp_h); end
            if (k >= 2) begin
                prev_h = ((k - 1) % (MAX + 1)) == 0;
                n_checks++; if (HostRValid !== prev_h || CpuRValid !== !prev_h)
                    begin n_errors++; $display("FAIL starve_rvalid: k=%0d crv=%b hrv=%b expected %b %b", k, CpuRValid, HostRValid, !prev_h, prev_h); end
                n_checks++; if ((prev_h ? HostRData : CpuRData) !== (prev_h ? init_val(8'h41) : init_val(8'h40)))
                    begin n_errors++; $display("FAIL starve_rdata: k=%0d data=%h expected %h", k, prev_h ? HostRData : CpuRData, prev_h ? init_val(8'h41) : init_val(8'h40)); end
            end
            if (k == 10) begin
                drive_cpu(0, 0, 0, 0);
                drive_host(0, 0, 0, 0);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drive_host(1, 0, 8'h00, 16'h0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_checks++; if (HostGnt !== (k <= 4) || CpuGnt !== 1'b0)
                begin n_errors++; $display("FAIL b2b_gnt: k=%0d host=%b cpu=%b expected %b 0", k, HostGnt, CpuGnt, k <= 4); end
            if (k <= 4) begin
                n_checks++; if (MemAddr !== 8'(k - 1)) begin n_errors++; $display("FAIL b2b_addr: k=%0d MemAddr=%h expected %h", k, MemAddr, 8'(k - 1)); end
            end
            n_checks++; if (HostRValid !== (k >= 2 && k <= 5))
                begin n_errors++; $display("FAIL b2b_rvalid: k=%0d HostRValid=%b expected %b", k, HostRValid, k >= 2 && k <= 5); end
            if (k >= 2 && k <= 5) begin
                n_checks++; if (HostRData !== init_val(8'(k - 2)))
                    begin n_errors++; $display("FAIL b2b_rdata: k=%0d HostRData=%h expected %h", k, HostRData, init_val(8'(k - 2))); end
            end
            if (k < 4) drive_host(1, 0, 8'(k), 16'h0);
            else       drive_host(0, 0, 0, 0);
        end
    endtask

    task automatic new_addr(output logic [7:0] a);
        // A narrow address range half the time produces read-after-write hazards.
        a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
    endtask

    task automatic test_random();
        int                wait_m   = 0;   // host cycles lost to the CPU in a row
        int                host_age = 0;   // cycles the current host request has been sampled
        int                g_owner  = 0;   // expected bus owner this cycle (0 none, 1 CPU, 2 host)
        logic              g_write  = 1'b0;
        logic [7:0]        g_addr   = '0;
        logic [15:0]       g_wdata  = '0;
        int                r_owner  = 0;   // port whose read returns this cycle
        logic [15:0]       r_data   = '0;
        logic              host_wins;
        logic [7:0]        a;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

        for (int cyc = 0; cyc < 2000; cyc++) begin
            n_checks++; if (CpuGnt !== (g_owner == 1) || HostGnt !== (g_owner == 2) || Owner !== 2'(g_owner))
                begin n_errors++; $display("FAIL rnd_gnt: cyc=%0d cpu=%b host=%b owner=%b expected owner %0d", cyc, CpuGnt, HostGnt, Owner, g_owner); end
            n_checks++; if (CpuGnt && HostGnt) begin n_errors++; $display("FAIL rnd_both_gnt: cyc=%0d both grants high, expected at most one", cyc); end
            n_checks++; if (MemWrite !== (g_owner != 0 && g_write))
                begin n_errors++; $display("FAIL rnd_we: cyc=%0d MemWrite=%b expected %b", cyc, MemWrite, g_owner != 0 && g_write); end
            if (g_owner != 0) begin
                n_checks++; if (MemAddr !== g_addr) begin n_errors++; $display("FAIL rnd_addr: cyc=%0d MemAddr=%h expected %h", cyc, MemAddr, g_addr); end
                if (g_write) begin
                    n_checks++; if (MemWData !== g_wdata) begin n_errors++; $display("FAIL rnd_wdata: cyc=%0d MemWData=%h expected %h", cyc, MemWData, g_wdata); end
                end
            end
            n_checks++; if (CpuRValid !== (r_owner == 1) || CpuRData !== ((r_owner == 1) ? r_data : 16'h0))
                begin n_errors++; $display("FAIL rnd_cpu_rd: cyc=%0d rvalid=%b data=%h expected %b %h", cyc, CpuRValid, CpuRData, r_owner == 1, (r_owner == 1) ? r_data : 16'h0); end
            n_checks++; if (HostRValid !== (r_owner == 2) || HostRData !== ((r_owner == 2) ? r_data : 16'h0))
                begin n_errors++; $display("FAIL rnd_host_rd: cyc=%0d rvalid=%b data=%h expected %b %h", cyc, HostRValid, HostRData, r_owner == 2, (r_owner == 2) ? r_data : 16'h0); end

            // Limit on host waiting. A request sampled for host_age cycles without a win has lost host_age cycles.
            if (HostGnt) begin
                n_checks++; if (host_age > MAX + 1) begin n_errors++; $display("FAIL rnd_starve: cyc=%0d host sampled %0d cycles, expected <= %0d", cyc, host_age, MAX + 1); end
                host_age = 0;
            end else if (HostReq) begin
                n_checks++; if (host_age > MAX) begin n_errors++; $display("FAIL rnd_starve_wait: cyc=%0d host waited %0d cycles, expected <= %0d", cyc, host_age, MAX); end
            end

            // Retire the access on the bus against the shadow memory.
            r_owner = 0;
            if (g_owner != 0) begin
                if (g_write) ref_mem[g_addr] = g_wdata;
                else begin r_owner = g_owner; r_data = ref_mem[g_addr]; end
            end

            // Requesters hold each request until they are granted, and may issue the next one back-to-back.
            if (!CpuReq || CpuGnt) begin
                if ($urandom_range(0, 99) < 70) begin
                    new_addr(a);
                    drive_cpu(1, 1'($urandom_range(0, 1)), a, 16'($urandom));
                end else drive_cpu(0, 0, 0, 0);
            end
            if (!HostReq || HostGnt) begin
                if ($urandom_range(0, 99) < 50) begin
                    new_addr(a);
                    drive_host(1, 1'($urandom_range(0, 1)), a, 16'($urandom));
                end else drive_host(0, 0, 0, 0);
            end

            // Reference arbitration for the requests just driven.
            host_wins = HostReq && (!CpuReq || wait_m >= MAX);
            if (host_wins) begin
                g_owner = 2; g_write = HostWrite; g_addr = HostAddr; g_wdata = HostWData;
            end else if (CpuReq) begin
                g_owner = 1; g_write = CpuWrite; g_addr = CpuAddr; g_wdata = CpuWData;
            end else begin
                g_owner = 0; g_write = 1'b0;
            end
            if (!HostReq || host_wins) wait_m = 0;
            else if (wait_m < MAX)     wait_m = wait_m + 1;
            if (HostReq) host_age = host_age + 1;

            tick();
        end
        drive_cpu(0, 0, 0, 0);
        drive_host(0, 0, 0, 0);
        tick(); tick(); tick();
    endtask

    initial begin : main
        test_reset();
        test_cpu_write_read();
        test_simultaneous();
        test_starvation();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
